// File: rtl/trigger_matrix_if.sv
// ---------------------------------------------------------------------------
// trigger_matrix_if
// Control-bus bundle for the trigger matrix register file.
//   ctrl_write      : single-cycle register write strobe
//   ctrl_address    : 4-bit register address
//   ctrl_writedata  : 32-bit register write data
// The master modport drives the bus; the slave modport is the matrix side.
// ---------------------------------------------------------------------------
interface trigger_matrix_if;
  logic        ctrl_write;
  logic [3:0]  ctrl_address;
  logic [31:0] ctrl_writedata;

  modport master (
    output ctrl_write,
    output ctrl_address,
    output ctrl_writedata
  );

  modport slave (
    input ctrl_write,
    input ctrl_address,
    input ctrl_writedata
  );
endinterface

// File: rtl/trigger_matrix.sv
// ---------------------------------------------------------------------------
// trigger_matrix
// Routes NSRC trigger sources to NDST trigger sinks. Each sink has a
// programmable source mask, a fixed-priority arbiter (lowest source index
// wins), a holdoff dead-time window, and saturating forwarded/dropped
// trigger counters.
//
// Ports:
//   clk         : system clock
//   reset_n     : asynchronous active-low reset
//   sync        : clock enable for all trigger state
//   ctrl        : control bus (slave modport of trigger_matrix_if)
//                   addr d      -> mask[d]    = writedata[NSRC-1:0]
//                   addr 8+d    -> holdoff[d] = writedata[HOLD_W-1:0]
//                   addr 15 b0  -> counter clear pulse
//   src_trg     : NSRC packed source words, source i at [i*W +: W]
//   dst_trg     : NDST packed sink words, same packing
//   trg_count   : NDST packed forwarded-trigger counters
//   drop_count  : NDST packed dropped-trigger counters
// ---------------------------------------------------------------------------
module trigger_matrix #(
  parameter int NSRC   = 6,
  parameter int NDST   = 3,
  parameter int W      = 5,
  parameter int HOLD_W = 16,
  parameter int CNT_W  = 32
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    sync,
  trigger_matrix_if.slave         ctrl,
  input  logic [NSRC*W-1:0]       src_trg,
  output logic [NDST*W-1:0]       dst_trg,
  output logic [NDST*CNT_W-1:0]   trg_count,
  output logic [NDST*CNT_W-1:0]   drop_count
);

  typedef enum logic {
    S_IDLE,
    S_HOLD
  } sinkState_t;

  logic r_clear;
  logic w_unused;

  // Only the low data bits are decoded; folding the whole bus here keeps
  // the remaining bits visibly accounted for.
  assign w_unused = ^ctrl.ctrl_writedata;

  // Counter clear is captured as a one-cycle pulse so counters zero on the
  // edge after the write, independent of sync.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_clear <= 1'b0;
    end else begin
      r_clear <= ctrl.ctrl_write && (ctrl.ctrl_address == 4'd15) &&
                 ctrl.ctrl_writedata[0];
    end
  end

  for (genvar d = 0; d < NDST; d++) begin : g_sink
    logic [NSRC-1:0]   r_mask;
    logic [HOLD_W-1:0] r_holdoff;
    sinkState_t        r_state;
    sinkState_t        w_stateNext;
    logic [HOLD_W-1:0] r_hold;
    logic [HOLD_W-1:0] w_holdNext;
    logic [W-1:0]      r_dst;
    logic [W-1:0]      w_dstNext;
    logic [CNT_W-1:0]  r_trgCnt;
    logic [CNT_W-1:0]  r_dropCnt;
    logic              w_trgInc;
    logic              w_dropInc;
    logic [NSRC-1:0]   w_cand;
    logic [W-1:0]      w_sel;
    logic              w_any;
    logic              w_multi;

    // Per-sink configuration registers; writes ignore sync.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_mask    <= '0;
        r_holdoff <= '0;
      end else if (ctrl.ctrl_write) begin
        if (ctrl.ctrl_address == 4'(d)) begin
          r_mask <= ctrl.ctrl_writedata[NSRC-1:0];
        end
        if (ctrl.ctrl_address == 4'(8 + d)) begin
          r_holdoff <= ctrl.ctrl_writedata[HOLD_W-1:0];
        end
      end
    end

    // Candidate set and priority select. Scanning from the top down lets
    // the lowest-index candidate overwrite everything above it.
    always_comb begin
      w_cand = '0;
      w_sel  = '0;
      for (int i = NSRC - 1; i >= 0; i--) begin
        w_cand[i] = r_mask[i] && (src_trg[i*W +: W] != '0);
        if (w_cand[i]) begin
          w_sel = src_trg[i*W +: W];
        end
      end
    end

    assign w_any   = |w_cand;
    // More than one bit set: clearing the lowest set bit leaves something.
    assign w_multi = (w_cand & (w_cand - NSRC'(1))) != '0;

    // Next-state logic: forwarding in IDLE, dead-time countdown in HOLD.
    always_comb begin
      w_stateNext = r_state;
      w_holdNext  = r_hold;
      w_dstNext   = r_dst;
      w_trgInc    = 1'b0;
      w_dropInc   = 1'b0;
      if (sync) begin
        case (r_state)
          S_IDLE: begin
            w_dstNext = '0;
            if (w_any) begin
              w_dstNext = w_sel;
              w_trgInc  = 1'b1;
              w_dropInc = w_multi;
              if (r_holdoff != '0) begin
                w_holdNext  = r_holdoff;
                w_stateNext = S_HOLD;
              end
            end
          end
          S_HOLD: begin
            w_dstNext  = '0;
            w_holdNext = r_hold - HOLD_W'(1);
            w_dropInc  = w_any;
            if (r_hold <= HOLD_W'(1)) begin
              w_holdNext  = '0;
              w_stateNext = S_IDLE;
            end
          end
          default: begin
            w_dstNext   = '0;
            w_holdNext  = '0;
            w_stateNext = S_IDLE;
          end
        endcase
      end
    end

    // Sink state register.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_state <= S_IDLE;
        r_hold  <= '0;
        r_dst   <= '0;
      end else begin
        r_state <= w_stateNext;
        r_hold  <= w_holdNext;
        r_dst   <= w_dstNext;
      end
    end

    // Saturating statistics counters; clear takes priority over increment.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_trgCnt  <= '0;
        r_dropCnt <= '0;
      end else if (r_clear) begin
        r_trgCnt  <= '0;
        r_dropCnt <= '0;
      end else begin
        if (w_trgInc && (r_trgCnt != '1)) begin
          r_trgCnt <= r_trgCnt + CNT_W'(1);
        end
        if (w_dropInc && (r_dropCnt != '1)) begin
          r_dropCnt <= r_dropCnt + CNT_W'(1);
        end
      end
    end

    assign dst_trg[d*W +: W]        = r_dst;
    assign trg_count[d*CNT_W +: CNT_W]  = r_trgCnt;
    assign drop_count[d*CNT_W +: CNT_W] = r_dropCnt;
  end

endmodule

// File: tb/tb_trigger_matrix.sv
// ---------------------------------------------------------------------------
// tb_trigger_matrix
// Self-checking bench for trigger_matrix: directed scenarios followed by
// randomized traffic, all compared against a behavioural sink model that
// tracks remaining dead-time cycles as a plain integer.
// ---------------------------------------------------------------------------
module tb_trigger_matrix;
  localparam int NSRC   = 6;
  localparam int NDST   = 3;
  localparam int W      = 5;
  localparam int HOLD_W = 16;
  localparam int CNT_W  = 32;
  localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;

  logic                  clk = 1'b0;
  logic                  reset_n = 1'b0;
  logic                  sync = 1'b0;
  logic [NSRC*W-1:0]     src_trg = '0;
  logic [NDST*W-1:0]     dst_trg;
  logic [NDST*CNT_W-1:0] trg_count;
  logic [NDST*CNT_W-1:0] drop_count;

  trigger_matrix_if ctrlIf ();

  trigger_matrix #(
    .NSRC(NSRC), .NDST(NDST), .W(W), .HOLD_W(HOLD_W), .CNT_W(CNT_W)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .sync      (sync),
    .ctrl      (ctrlIf.slave),
    .src_trg   (src_trg),
    .dst_trg   (dst_trg),
    .trg_count (trg_count),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  // Reference model state
  int     mMask   [NDST];
  int     mHoldoff[NDST];
  int     mRemain [NDST];
  int     mDst    [NDST];
  longint mTrg    [NDST];
  longint mDrop   [NDST];
  bit     mClear;

  int checks = 0;
  int errors = 0;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Model reset: everything zero, every sink idle.
  task automatic modelReset();
    for (int d = 0; d < NDST; d++) begin
      mMask[d] = 0; mHoldoff[d] = 0; mRemain[d] = 0;
      mDst[d] = 0; mTrg[d] = 0; mDrop[d] = 0;
    end
    mClear = 1'b0;
  endtask

  function automatic longint satInc(input longint v);
    return (v < CNT_MAX) ? v + 1 : v;
  endfunction

  // One clock edge of the reference behaviour using pre-edge register state.
  task automatic modelStep(input bit s, input bit wr, input int addr, input int data,
                           input logic [NSRC*W-1:0] src);
    for (int d = 0; d < NDST; d++) begin
      if (s) begin
        int cnt = 0;
        int first = 0;
        for (int i = 0; i < NSRC; i++) begin
          int word = int'(src[i*W +: W]);
          if ((((mMask[d] >> i) & 1) == 1) && word != 0) begin
            if (cnt == 0) first = word;
            cnt++;
          end
        end
        if (mRemain[d] > 0) begin
          mDst[d] = 0;
          if (cnt > 0) mDrop[d] = satInc(mDrop[d]);
          mRemain[d]--;
        end else begin
          mDst[d] = first;
          if (cnt > 0) begin
            mTrg[d] = satInc(mTrg[d]);
            mRemain[d] = mHoldoff[d];
          end
          if (cnt > 1) mDrop[d] = satInc(mDrop[d]);
        end
      end
      if (mClear) begin
        mTrg[d] = 0;
        mDrop[d] = 0;
      end
    end
    mClear = wr && (addr == 15) && ((data & 1) == 1);
    if (wr) begin
      for (int d = 0; d < NDST; d++) begin
        if (addr == d)     mMask[d]    = data & ((1 << NSRC) - 1);
        if (addr == 8 + d) mHoldoff[d] = data & ((1 << HOLD_W) - 1);
      end
    end
  endtask

  task automatic checkAll(input string phase);
    for (int d = 0; d < NDST; d++) begin
      checkOutput($sformatf("%s_dst%0d", phase, d), 64'(dst_trg[d*W +: W]), 64'(mDst[d]));
      checkOutput($sformatf("%s_trg%0d", phase, d), 64'(trg_count[d*CNT_W +: CNT_W]), 64'(mTrg[d]));
      checkOutput($sformatf("%s_drop%0d", phase, d), 64'(drop_count[d*CNT_W +: CNT_W]), 64'(mDrop[d]));
    end
  endtask

  // Drive one cycle of inputs, advance the model over the edge, then check.
  task automatic applyStimulus(input string phase, input bit s, input bit wr,
                               input int addr, input int data,
                               input logic [NSRC*W-1:0] src);
    sync                  = s;
    ctrlIf.ctrl_write     = wr;
    ctrlIf.ctrl_address   = 4'(addr);
    ctrlIf.ctrl_writedata = 32'(data);
    src_trg               = src;
    @(posedge clk);
    modelStep(s, wr, addr, data, src);
    #1;
    checkAll(phase);
  endtask

  task automatic idleCycles(input string phase, input int n, input bit s);
    for (int k = 0; k < n; k++) applyStimulus(phase, s, 1'b0, 0, 0, '0);
  endtask

  task automatic writeReg(input string phase, input int addr, input int data);
    applyStimulus(phase, 1'b0, 1'b1, addr, data, '0);
  endtask

  function automatic logic [NSRC*W-1:0] srcWord(input int idx, input int word);
    logic [NSRC*W-1:0] v = '0;
    v[idx*W +: W] = W'(word);
    return v;
  endfunction

  initial begin
    logic [NSRC*W-1:0] rsrc;
    ctrlIf.ctrl_write = 1'b0;
    ctrlIf.ctrl_address = '0;
    ctrlIf.ctrl_writedata = '0;
    modelReset();
    #3;
    checkAll("reset");
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Single routing
    writeReg("route", 0, 'h04);
    applyStimulus("route", 1'b1, 1'b0, 0, 0, srcWord(2, 'b00010));
    checkOutput("route_dst0_value", 64'(dst_trg[4:0]), 64'h02);
    idleCycles("route", 1, 1'b1);
    checkOutput("route_trg0_total", 64'(trg_count[CNT_W-1:0]), 64'd1);

    // Collision priority
    writeReg("prio", 1, 'h0A);
    applyStimulus("prio", 1'b1, 1'b0, 0, 0, srcWord(1, 'b00100) | srcWord(3, 'b01000));
    checkOutput("prio_dst1_value", 64'(dst_trg[W +: W]), 64'h04);
    checkOutput("prio_drop1_total", 64'(drop_count[CNT_W +: CNT_W]), 64'd1);

    // Holdoff window of 3
    writeReg("hold", 15, 1);
    idleCycles("hold", 1, 1'b0);
    writeReg("hold", 0, 'h01);
    writeReg("hold", 8, 3);
    for (int k = 0; k < 5; k++) applyStimulus("hold", 1'b1, 1'b0, 0, 0, srcWord(0, 'b00010));
    checkOutput("hold_trg0_total", 64'(trg_count[CNT_W-1:0]), 64'd2);
    checkOutput("hold_drop0_total", 64'(drop_count[CNT_W-1:0]), 64'd3);
    idleCycles("hold", 4, 1'b1);

    // Zero holdoff, back-to-back with sync at 1:2
    writeReg("b2b", 8, 0);
    writeReg("b2b", 15, 1);
    idleCycles("b2b", 1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus("b2b", 1'b1, 1'b0, 0, 0, srcWord(0, 'b00010));
      applyStimulus("b2b", 1'b0, 1'b0, 0, 0, srcWord(0, 'b00010));
      applyStimulus("b2b", 1'b0, 1'b0, 0, 0, srcWord(0, 'b00010));
    end
    checkOutput("b2b_trg0_total", 64'(trg_count[CNT_W-1:0]), 64'd4);
    idleCycles("b2b", 1, 1'b1);

    // Fan-out and clear racing a trigger
    writeReg("fan", 0, 'h10);
    writeReg("fan", 2, 'h10);
    writeReg("fan", 15, 1);
    idleCycles("fan", 1, 1'b0);
    applyStimulus("fan", 1'b1, 1'b0, 0, 0, srcWord(4, 'b00001));
    checkOutput("fan_trg2_total", 64'(trg_count[2*CNT_W +: CNT_W]), 64'd1);
    applyStimulus("fan", 1'b1, 1'b1, 15, 1, srcWord(4, 'b00011));
    idleCycles("fan", 1, 1'b0);
    checkOutput("fan_trg0_cleared", 64'(trg_count[CNT_W-1:0]), 64'd0);

    // Async reset in the middle of a long holdoff
    writeReg("arst", 0, 'h01);
    writeReg("arst", 8, 100);
    applyStimulus("arst", 1'b1, 1'b0, 0, 0, srcWord(0, 'b00111));
    idleCycles("arst", 2, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    modelReset();
    checkAll("arst_low");
    #1;
    reset_n = 1'b1;
    for (int k = 0; k < 2; k++) applyStimulus("arst_post", 1'b1, 1'b0, 0, 0, srcWord(0, 'b00111));
    checkOutput("arst_dst0_masked", 64'(dst_trg[4:0]), 64'd0);

    // Randomized traffic with occasional register writes
    for (int d = 0; d < NDST; d++) writeReg("rnd_cfg", d, int'($urandom_range(1, (1 << NSRC) - 1)));
    for (int n = 0; n < 2000; n++) begin
      bit s  = ($urandom_range(0, 2) != 0);
      bit wr = ($urandom_range(0, 15) == 0);
      int addr = int'($urandom_range(0, 15));
      int data = int'($urandom);
      if (addr >= 8 && addr < 15) data = int'($urandom_range(0, 5));
      if (addr == 15) data = ($urandom_range(0, 3) == 0) ? 1 : 0;
      rsrc = '0;
      for (int i = 0; i < NSRC; i++) begin
        if ($urandom_range(0, 9) < 3) rsrc[i*W +: W] = W'($urandom_range(1, (1 << W) - 1));
      end
      applyStimulus("rnd", s, wr, addr, data, rsrc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
